mem_stage_access_unit: RTL and testbench
========================================

Name: mem_stage_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. It turns MEM_memory_read / MEM_memory_write, MEM_funct3, MEM_alu_result (the address) and MEM_read_data2 (the store data) into a req/ready data-memory bus transaction. It formats load data by byte lane with sign or zero extension. It stalls the pipeline until the access completes, faults or times out.

Parameters:
XLEN, 32, datapath width; byte-lane logic is defined for 32 only.
WAIT_LIMIT, 16, maximum number of REQ-state cycles without dmem_ready before access_fault is raised.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
MEM_memory_read  input  1  load in MEM stage
MEM_memory_write  input  1  store in MEM stage
MEM_funct3  input  3  load/store width code
MEM_alu_result  input  XLEN  byte address
MEM_read_data2  input  XLEN  store data (rs2)
dmem_req  output  1  bus request, registered
dmem_we  output  1  1 = write, registered
dmem_addr  output  XLEN  word-aligned address, registered
dmem_wdata  output  XLEN  lane-replicated store data, registered
dmem_wstrb  output  XLEN/8  byte write strobes, registered
dmem_ready  input  1  bus accepts/completes in the same cycle
dmem_rdata  input  XLEN  read word, valid when dmem_ready=1
mem_stall  output  1  freeze IF..EX/MEM, combinational
load_data  output  XLEN  formatted load result, registered
load_valid  output  1  one-cycle pulse, successful load
mem_op_done  output  1  one-cycle pulse, any op finished
misaligned  output  1  valid during DONE only
access_fault  output  1  valid during DONE only

Behaviour:
- Reset:
  - state = IDLE, wait counter = 0.
  - All registered outputs = 0.
  - mem_stall = 0 while reset is high.
  - Reset mid-REQ: dmem_req drops at that edge; no DONE pulse is produced.
- Op present when MEM_memory_read or MEM_memory_write = 1. If both are set, the op is treated as a write.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code gives no bus access and access_fault = 1.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 00. A misaligned op gives no bus access and misaligned = 1.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - No op: stay in IDLE.
  - Legal, aligned op: register the bus fields, set dmem_req = 1, go to REQ.
  - Misaligned or illegal op: register the fault flags, go to DONE.
- REQ:
  - dmem_ready = 1: drop dmem_req, capture formatted data (loads), go to DONE.
  - Otherwise increment the counter. When counter = WAIT_LIMIT-1 with no ready: drop req, set access_fault, go to DONE.
  - Counter is cleared on leaving REQ.
- DONE:
  - Exactly one cycle; mem_op_done = 1.
  - load_valid = 1 only for a successful load.
  - Flags and load_data are valid; next state is IDLE unconditionally.
  - No new request is issued in DONE, so the same instruction, still at the inputs, is never re-issued.
- mem_stall = (state==IDLE && op present) || state==REQ. It is 0 in DONE, so EX/MEM advances at the end of the DONE cycle.
- Latency: a zero-wait-state memory costs 2 stall cycles (IDLE, REQ) plus the DONE cycle.
- dmem_addr = {addr[XLEN-1:2], 2'b00}.
- Store data and strobes:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011 << addr[1:0].
  - SW: wdata = rs2, wstrb = 1111.
- For loads, dmem_we = 0 and wstrb = 0000.
- Load formatting:
  - Select byte = rdata[8*addr[1:0] +: 8]; halfword = rdata[16*addr[1] +: 16].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes the word through.
- Fault outcomes force load_data = 0.
- Flags and load_data hold from the DONE cycle until the next DONE cycle; consumers sample them only on the mem_op_done cycle.
- dmem_ready outside REQ is ignored.

Test Plan:
1. Reset held 3 cycles, then released with no op -> all outputs 0, mem_stall = 0, dmem_req never asserted.
2. SW addr 0x1000_0040, rs2 0xDEADBEEF, ready on the first REQ cycle:
   - dmem_addr = 0x1000_0040, wdata = 0xDEADBEEF, wstrb = 1111, we = 1.
   - Stall for 2 cycles, then mem_op_done pulse with load_valid = 0.
3. LB addr 0x2000_0033, rdata 0x80FF_7F01, 2 wait cycles:
   - load_data = 0xFFFF_FF80, load_valid pulse.
   - Stall for 4 cycles.
   - Repeat as LBU -> 0x0000_0080.
4. SH addr 0x0000_0012, rs2 0x0000_ABCD -> wdata = 0xABCD_ABCD, wstrb = 1100. LH at 0x0000_0011 -> no dmem_req, misaligned = 1 in the DONE cycle.
5. LW with dmem_ready held 0 and WAIT_LIMIT = 16:
   - dmem_req high for 16 cycles, then access_fault = 1 and load_data = 0, DONE, stall released.
   - Rerun with reset asserted in REQ cycle 5 -> state IDLE, no mem_op_done pulse.
6. Back-to-back: load at 0x8 followed by store at 0xC in the next EX/MEM slot -> two separate transactions, no duplicate request for the first op.

Source files
------------

// File: rtl/mem_stage_access_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_access_unit
//
// MEM-stage data-memory access unit. Takes the load/store controls, funct3,
// byte address and store data coming out of the EX/MEM pipeline register,
// runs one req/ready bus transaction per op, formats load data per byte lane
// (sign/zero extension) and holds the pipeline with mem_stall until the op
// has completed, faulted (misaligned / illegal funct3) or timed out.
//
// Ports:
//   clk, reset                      rising-edge clock, sync active-high reset
//   MEM_memory_read/_write          op present (write wins if both are set)
//   MEM_funct3                      load/store width code
//   MEM_alu_result                  byte address
//   MEM_read_data2                  store data (rs2)
//   dmem_req/we/addr/wdata/wstrb    registered bus request fields
//   dmem_ready, dmem_rdata          bus completion and read word
//   mem_stall                       combinational freeze of IF..EX/MEM
//   load_data, load_valid           formatted load result and its pulse
//   mem_op_done                     one-cycle pulse when any op finishes
//   misaligned, access_fault        outcome flags, meaningful on mem_op_done
// -----------------------------------------------------------------------------
module mem_stage_access_unit #(
    parameter int XLEN       = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEM_memory_read,
    input  logic              MEM_memory_write,
    input  logic [2:0]        MEM_funct3,
    input  logic [XLEN-1:0]   MEM_alu_result,
    input  logic [XLEN-1:0]   MEM_read_data2,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_wstrb,
    input  logic              dmem_ready,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_stall,
    output logic [XLEN-1:0]   load_data,
    output logic              load_valid,
    output logic              mem_op_done,
    output logic              misaligned,
    output logic              access_fault
);

    localparam int NB = XLEN / 8;
    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     wait_cnt_reg;

    logic              dmem_req_reg;
    logic              dmem_we_reg;
    logic [XLEN-1:0]   dmem_addr_reg;
    logic [XLEN-1:0]   dmem_wdata_reg;
    logic [NB-1:0]     dmem_wstrb_reg;
    logic [XLEN-1:0]   load_data_reg;
    logic              load_valid_reg;
    logic              mem_op_done_reg;
    logic              misaligned_reg;
    logic              access_fault_reg;

    // Op attributes kept for formatting the read word while in REQ.
    logic              is_load_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        off_reg;

    // ------------------------------------------------------------------
    // Request decode (IDLE-cycle view of the EX/MEM register)
    // ------------------------------------------------------------------
    logic              op_present;
    logic              is_store;
    logic [1:0]        size;
    logic [1:0]        off;
    logic              funct3_legal;
    logic              addr_misaligned;
    logic [XLEN-1:0]   store_wdata;
    logic [NB-1:0]     lane_strb;

    assign op_present = MEM_memory_read | MEM_memory_write;
    assign is_store   = MEM_memory_write;
    assign size       = MEM_funct3[1:0];
    assign off        = MEM_alu_result[1:0];

    always_comb begin
        funct3_legal = 1'b0;
        if (is_store) begin
            case (MEM_funct3)
                3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
                default:                funct3_legal = 1'b0;
            endcase
        end else begin
            case (MEM_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_legal = 1'b1;
                default:                                funct3_legal = 1'b0;
            endcase
        end
    end

    assign addr_misaligned = ((size == 2'b01) && off[0]) ||
                             ((size == 2'b10) && (off != 2'b00));

    // Store data is replicated across lanes so the strobes alone pick the bytes.
    always_comb begin
        store_wdata = MEM_read_data2;
        case (size)
            2'b00:   store_wdata = {4{MEM_read_data2[7:0]}};
            2'b01:   store_wdata = {2{MEM_read_data2[15:0]}};
            default: store_wdata = MEM_read_data2;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-lane strobes and read lanes
    // ------------------------------------------------------------------
    logic [7:0] rd_lane [NB];

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign rd_lane[gi]   = dmem_rdata[8*gi +: 8];
            assign lane_strb[gi] = (size == 2'b10) ||
                                   ((size == 2'b00) && (off == 2'(gi))) ||
                                   ((size == 2'b01) && (off[1] == (((gi / 2) % 2) == 1)));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load formatting from the returned word
    // ------------------------------------------------------------------
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_formatted;

    assign ld_byte = rd_lane[off_reg];
    assign ld_half = {rd_lane[{off_reg[1], 1'b1}], rd_lane[{off_reg[1], 1'b0}]};

    always_comb begin
        ld_formatted = '0;
        case (funct3_reg)
            3'b000:  ld_formatted = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_formatted = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b010:  ld_formatted = dmem_rdata;
            3'b100:  ld_formatted = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_formatted = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_formatted = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            wait_cnt_reg     <= '0;
            dmem_req_reg     <= 1'b0;
            dmem_we_reg      <= 1'b0;
            dmem_addr_reg    <= '0;
            dmem_wdata_reg   <= '0;
            dmem_wstrb_reg   <= '0;
            load_data_reg    <= '0;
            load_valid_reg   <= 1'b0;
            mem_op_done_reg  <= 1'b0;
            misaligned_reg   <= 1'b0;
            access_fault_reg <= 1'b0;
            is_load_reg      <= 1'b0;
            funct3_reg       <= 3'b000;
            off_reg          <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    mem_op_done_reg <= 1'b0;
                    load_valid_reg  <= 1'b0;
                    if (op_present) begin
                        if (!funct3_legal || addr_misaligned) begin
                            // Illegal code takes precedence over alignment.
                            access_fault_reg <= !funct3_legal;
                            misaligned_reg   <= funct3_legal;
                            load_data_reg    <= '0;
                            mem_op_done_reg  <= 1'b1;
                            state_reg        <= DONE;
                        end else begin
                            dmem_req_reg   <= 1'b1;
                            dmem_we_reg    <= is_store;
                            dmem_addr_reg  <= {MEM_alu_result[XLEN-1:2], 2'b00};
                            dmem_wdata_reg <= is_store ? store_wdata : '0;
                            dmem_wstrb_reg <= is_store ? lane_strb : '0;
                            is_load_reg    <= !is_store;
                            funct3_reg     <= MEM_funct3;
                            off_reg        <= off;
                            wait_cnt_reg   <= '0;
                            state_reg      <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (dmem_ready) begin
                        dmem_req_reg     <= 1'b0;
                        load_data_reg    <= is_load_reg ? ld_formatted : '0;
                        load_valid_reg   <= is_load_reg;
                        misaligned_reg   <= 1'b0;
                        access_fault_reg <= 1'b0;
                        mem_op_done_reg  <= 1'b1;
                        wait_cnt_reg     <= '0;
                        state_reg        <= DONE;
                    end else if (wait_cnt_reg == CW'(WAIT_LIMIT - 1)) begin
                        dmem_req_reg     <= 1'b0;
                        load_data_reg    <= '0;
                        load_valid_reg   <= 1'b0;
                        misaligned_reg   <= 1'b0;
                        access_fault_reg <= 1'b1;
                        mem_op_done_reg  <= 1'b1;
                        wait_cnt_reg     <= '0;
                        state_reg        <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end

                DONE: begin
                    // The finished op may still sit at the inputs here; it is
                    // not looked at, so it can never be issued twice.
                    mem_op_done_reg <= 1'b0;
                    load_valid_reg  <= 1'b0;
                    state_reg       <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Released in DONE so EX/MEM advances at the end of that cycle.
    assign mem_stall = !reset &&
                       (((state_reg == IDLE) && op_present) || (state_reg == REQ));

    assign dmem_req     = dmem_req_reg;
    assign dmem_we      = dmem_we_reg;
    assign dmem_addr    = dmem_addr_reg;
    assign dmem_wdata   = dmem_wdata_reg;
    assign dmem_wstrb   = dmem_wstrb_reg;
    assign load_data    = load_data_reg;
    assign load_valid   = load_valid_reg;
    assign mem_op_done  = mem_op_done_reg;
    assign misaligned   = misaligned_reg;
    assign access_fault = access_fault_reg;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_access_unit
//
// Directed bench for mem_stage_access_unit: a linear sequence of loads,
// stores, faults, a timeout and a reset during REQ, each checked with an
// immediate assertion against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mem_stage_access_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            MEM_memory_read;
    logic            MEM_memory_write;
    logic [2:0]      MEM_funct3;
    logic [XLEN-1:0] MEM_alu_result;
    logic [XLEN-1:0] MEM_read_data2;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;
    logic            mem_stall;
    logic [XLEN-1:0] load_data;
    logic            load_valid;
    logic            mem_op_done;
    logic            misaligned;
    logic            access_fault;

    int n_assert = 0;
    int n_fail   = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    mem_stage_access_unit #(.XLEN(XLEN), .WAIT_LIMIT(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .MEM_memory_read  (MEM_memory_read),
        .MEM_memory_write (MEM_memory_write),
        .MEM_funct3       (MEM_funct3),
        .MEM_alu_result   (MEM_alu_result),
        .MEM_read_data2   (MEM_read_data2),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_ready       (dmem_ready),
        .dmem_rdata       (dmem_rdata),
        .mem_stall        (mem_stall),
        .load_data        (load_data),
        .load_valid       (load_valid),
        .mem_op_done      (mem_op_done),
        .misaligned       (misaligned),
        .access_fault     (access_fault)
    );

    // Counts distinct bus requests (rising edges of dmem_req).
    always @(posedge clk) begin
        if (dmem_req && !req_prev) req_rises <= req_rises + 1;
        req_prev <= dmem_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Move 2 time units past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_op();
        MEM_memory_read  = 1'b0;
        MEM_memory_write = 1'b0;
        MEM_funct3       = 3'b000;
        MEM_alu_result   = '0;
        MEM_read_data2   = '0;
    endtask

    // Runs one bus op from IDLE: waits cycles without ready, then ready with
    // rdata. Leaves the DUT in IDLE with the op removed from the inputs.
    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input int waits,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                          input logic [31:0] exp_ld);
        MEM_memory_read  = rd;
        MEM_memory_write = wr;
        MEM_funct3       = f3;
        MEM_alu_result   = addr;
        MEM_read_data2   = rs2;
        #1;
        chk({tag, " idle stall"}, 32'(mem_stall), 32'd1);
        chk({tag, " idle req"},   32'(dmem_req),  32'd0);
        tick();
        chk({tag, " req"},   32'(dmem_req),   32'd1);
        chk({tag, " we"},    32'(dmem_we),    32'(wr));
        chk({tag, " addr"},  dmem_addr,       exp_addr);
        chk({tag, " wstrb"}, 32'(dmem_wstrb), 32'(exp_wstrb));
        if (wr) chk({tag, " wdata"}, dmem_wdata, exp_wdata);
        for (int i = 0; i < waits; i++) begin
            chk({tag, " wait req"},   32'(dmem_req),  32'd1);
            chk({tag, " wait stall"}, 32'(mem_stall), 32'd1);
            tick();
        end
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        #1;
        chk({tag, " ready stall"}, 32'(mem_stall), 32'd1);
        tick();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h5A5A_5A5A;
        // DONE cycle: the op is still at the inputs
        chk({tag, " done"},      32'(mem_op_done),  32'd1);
        chk({tag, " done req"},  32'(dmem_req),     32'd0);
        chk({tag, " done stall"},32'(mem_stall),    32'd0);
        chk({tag, " lvalid"},    32'(load_valid),   32'(rd && !wr));
        chk({tag, " misalign"},  32'(misaligned),   32'd0);
        chk({tag, " fault"},     32'(access_fault), 32'd0);
        if (rd && !wr) chk({tag, " load_data"}, load_data, exp_ld);
        tick();
        clear_op();
        chk({tag, " after done"}, 32'(mem_op_done), 32'd0);
        chk({tag, " after req"},  32'(dmem_req),    32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        clear_op();

        // 1. Reset held 3 cycles, released with no op
        repeat (3) begin
            tick();
            chk("rst stall", 32'(mem_stall), 32'd0);
            chk("rst req",   32'(dmem_req),  32'd0);
        end
        reset = 1'b0;
        tick();
        chk("post rst req",    32'(dmem_req),     32'd0);
        chk("post rst we",     32'(dmem_we),      32'd0);
        chk("post rst addr",   dmem_addr,         32'd0);
        chk("post rst wdata",  dmem_wdata,        32'd0);
        chk("post rst wstrb",  32'(dmem_wstrb),   32'd0);
        chk("post rst ldata",  load_data,         32'd0);
        chk("post rst lvalid", 32'(load_valid),   32'd0);
        chk("post rst done",   32'(mem_op_done),  32'd0);
        chk("post rst mis",    32'(misaligned),   32'd0);
        chk("post rst fault",  32'(access_fault), 32'd0);
        chk("post rst stall",  32'(mem_stall),    32'd0);
        $display("txn reset: done");

        // 2. SW, zero wait states
        run_op("SW", 1'b0, 1'b1, 3'b010, 32'h1000_0040, 32'hDEAD_BEEF, 0, 32'h0,
               32'h1000_0040, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        $display("txn SW addr=0x10000040 data=0xdeadbeef");

        // 3. LB / LBU with 2 wait cycles, byte lane 3
        run_op("LB", 1'b1, 1'b0, 3'b000, 32'h2000_0033, 32'h0, 2, 32'h80FF_7F01,
               32'h2000_0030, 32'h0, 4'b0000, 32'hFFFF_FF80);
        $display("txn LB addr=0x20000033 -> 0x%08h", load_data);
        run_op("LBU", 1'b1, 1'b0, 3'b100, 32'h2000_0033, 32'h0, 2, 32'h80FF_7F01,
               32'h2000_0030, 32'h0, 4'b0000, 32'h0000_0080);
        $display("txn LBU addr=0x20000033 -> 0x%08h", load_data);

        // 3b. LH upper half sign-extends, LHU lower half zero-extends
        run_op("LH", 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h8001_7FFE,
               32'h0000_0100, 32'h0, 4'b0000, 32'hFFFF_8001);
        $display("txn LH addr=0x00000102 -> 0x%08h", load_data);
        run_op("LHU", 1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 0, 32'h8001_F00D,
               32'h0000_0100, 32'h0, 4'b0000, 32'h0000_F00D);
        $display("txn LHU addr=0x00000100 -> 0x%08h", load_data);

        // 4. SH upper half, then misaligned LH
        run_op("SH", 1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 0, 32'h0,
               32'h0000_0010, 32'hABCD_ABCD, 4'b1100, 32'h0);
        $display("txn SH addr=0x00000012 data=0x0000abcd");
        run_op("SB", 1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'h1234_5677, 0, 32'h0,
               32'h0000_0020, 32'h7777_7777, 4'b0010, 32'h0);
        $display("txn SB addr=0x00000021 data=0x12345677");

        MEM_memory_read = 1'b1;
        MEM_funct3      = 3'b001;
        MEM_alu_result  = 32'h0000_0011;
        #1;
        chk("LHmis idle stall", 32'(mem_stall), 32'd1);
        tick();
        chk("LHmis req",    32'(dmem_req),     32'd0);
        chk("LHmis done",   32'(mem_op_done),  32'd1);
        chk("LHmis flag",   32'(misaligned),   32'd1);
        chk("LHmis fault",  32'(access_fault), 32'd0);
        chk("LHmis lvalid", 32'(load_valid),   32'd0);
        chk("LHmis ldata",  load_data,         32'd0);
        chk("LHmis stall",  32'(mem_stall),    32'd0);
        tick();
        clear_op();
        chk("LHmis after done", 32'(mem_op_done), 32'd0);
        $display("txn LH misaligned addr=0x00000011");

        // 4b. Illegal store funct3
        MEM_memory_write = 1'b1;
        MEM_funct3       = 3'b011;
        MEM_alu_result   = 32'h0000_0040;
        tick();
        chk("ILL req",   32'(dmem_req),     32'd0);
        chk("ILL done",  32'(mem_op_done),  32'd1);
        chk("ILL fault", 32'(access_fault), 32'd1);
        chk("ILL mis",   32'(misaligned),   32'd0);
        tick();
        clear_op();
        $display("txn illegal store funct3=011");

        // 5. LW never acknowledged: timeout after 16 REQ cycles
        MEM_memory_read = 1'b1;
        MEM_funct3      = 3'b010;
        MEM_alu_result  = 32'h0000_0080;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("TO req",   32'(dmem_req),  32'd1);
            chk("TO stall", 32'(mem_stall), 32'd1);
            tick();
        end
        chk("TO done",   32'(mem_op_done),  32'd1);
        chk("TO fault",  32'(access_fault), 32'd1);
        chk("TO ldata",  load_data,         32'd0);
        chk("TO lvalid", 32'(load_valid),   32'd0);
        chk("TO req off",32'(dmem_req),     32'd0);
        chk("TO stall",  32'(mem_stall),    32'd0);
        tick();
        clear_op();
        $display("txn LW timeout addr=0x00000080");

        // 5b. Reset in REQ cycle 5
        MEM_memory_read = 1'b1;
        MEM_funct3      = 3'b010;
        MEM_alu_result  = 32'h0000_0080;
        tick();
        repeat (4) tick();
        chk("RST5 req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("RST5 stall", 32'(mem_stall), 32'd0);
        tick();
        chk("RST5 req drop", 32'(dmem_req),    32'd0);
        chk("RST5 no done",  32'(mem_op_done), 32'd0);
        clear_op();
        reset = 1'b0;
        repeat (3) begin
            tick();
            chk("RST5 idle done",  32'(mem_op_done), 32'd0);
            chk("RST5 idle stall", 32'(mem_stall),   32'd0);
        end
        $display("txn LW reset during REQ");

        // 6. Back-to-back: LW at 0x8 then SW at 0xC in the next slot
        run_op("B2B LW", 1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0, 0, 32'h1234_5678,
               32'h0000_0008, 32'h0, 4'b0000, 32'h1234_5678);
        $display("txn B2B LW addr=0x00000008 -> 0x%08h", load_data);
        run_op("B2B SW", 1'b0, 1'b1, 3'b010, 32'h0000_000C, 32'hCAFE_F00D, 0, 32'h0,
               32'h0000_000C, 32'hCAFE_F00D, 4'b1111, 32'h0);
        $display("txn B2B SW addr=0x0000000c data=0xcafef00d");

        // SW,LB,LBU,LH,LHU,SH,SB,LW(timeout),LW(reset),LW,SW
        repeat (2) tick();
        chk("request count", 32'(req_rises), 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
